// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: widths, tag ranges,
// the broadcast record and the producer class encoding.
package cdb_pkg;

  localparam int WORD_SIZE = 32;
  localparam int UNIT_SIZE = 8;

  // Unit tag ranges owned by each producer class (inclusive)
  localparam logic [UNIT_SIZE-1:0] LW_BASE  = 8'h80;
  localparam logic [UNIT_SIZE-1:0] LW_LAST  = 8'hDF;
  localparam logic [UNIT_SIZE-1:0] ADD_BASE = 8'h20;
  localparam logic [UNIT_SIZE-1:0] ADD_LAST = 8'h3F;
  localparam logic [UNIT_SIZE-1:0] MUL_BASE = 8'h40;
  localparam logic [UNIT_SIZE-1:0] MUL_LAST = 8'h5F;

  typedef struct packed {
    logic                 valid;
    logic [UNIT_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0] data;
  } cdb_t;

  // Producer classes; the numeric order is also the round-robin order
  typedef enum logic [1:0] {
    CLS_LW  = 2'd0,
    CLS_ADD = 2'd1,
    CLS_MUL = 2'd2
  } cls_e;

  // Class that follows c in round-robin order
  function automatic cls_e next_cls(input cls_e c);
    cls_e n;
    case (c)
      CLS_LW:  n = CLS_ADD;
      CLS_ADD: n = CLS_MUL;
      default: n = CLS_LW;
    endcase
    return n;
  endfunction

  // True when tag belongs to the range owned by class c
  function automatic logic tag_in_range(input cls_e c, input logic [UNIT_SIZE-1:0] tag);
    logic ok;
    case (c)
      CLS_LW:  ok = (tag >= LW_BASE)  && (tag <= LW_LAST);
      CLS_ADD: ok = (tag >= ADD_BASE) && (tag <= ADD_LAST);
      CLS_MUL: ok = (tag >= MUL_BASE) && (tag <= MUL_LAST);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO holding finished results of one producer class.
// The head is read combinationally so a grant can register it onto the CDB
// in the same cycle it is popped.
module cdb_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             do_push, do_pop;

  // With DEPTH a power of two, occupancy < DEPTH is simply a clear MSB
  assign ready     = !occ_q[AW];
  assign occupancy = occ_q;
  assign head      = mem_q[rd_ptr_q];

  // Next pointers and occupancy; push and pop in one cycle leave occupancy alone
  always_comb begin
    do_push  = push && ready;
    do_pop   = pop && (occ_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      occ_d = occ_q - (AW+1)'(1);
    end
  end

  // Control state, cleared by reset so queued results are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents are meaningless until written so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three class FIFOs (lw/add/mul), tag range check,
// round-robin grant and a registered single-result-per-cycle broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lw_valid,
  input  logic [UNIT_SIZE-1:0] lw_tag,
  input  logic [WORD_SIZE-1:0] lw_data,
  output logic                 lw_ready,
  input  logic                 add_valid,
  input  logic [UNIT_SIZE-1:0] add_tag,
  input  logic [WORD_SIZE-1:0] add_data,
  output logic                 add_ready,
  input  logic                 mul_valid,
  input  logic [UNIT_SIZE-1:0] mul_tag,
  input  logic [WORD_SIZE-1:0] mul_data,
  output logic                 mul_ready,
  output logic                 cdb_valid,
  output logic [UNIT_SIZE-1:0] cdb_tag,
  output logic [WORD_SIZE-1:0] cdb_data,
  output logic                 tag_err,
  output logic [15:0]          bcast_count
);

  localparam int ENTRY_W = UNIT_SIZE + WORD_SIZE;
  localparam int OCC_W   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                 valid;
    logic [UNIT_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0] data;
  } bus_t;

  logic [2:0]           in_valid, in_ready, legal, push, bad, nonempty, pop;
  logic [UNIT_SIZE-1:0] in_tag  [3];
  logic [WORD_SIZE-1:0] in_data [3];
  logic [ENTRY_W-1:0]   head    [3];
  logic [OCC_W-1:0]     occ     [3];

  logic                 found;
  cls_e                 grant_cls, cand;
  logic [ENTRY_W-1:0]   sel_entry;

  bus_t                 cdb_q, cdb_d;
  cls_e                 rr_ptr_q, rr_ptr_d;
  logic                 tag_err_q, tag_err_d;
  logic [15:0]          bcast_count_q, bcast_count_d;

  assign in_valid   = {mul_valid, add_valid, lw_valid};
  assign in_tag[0]  = lw_tag;
  assign in_tag[1]  = add_tag;
  assign in_tag[2]  = mul_tag;
  assign in_data[0] = lw_data;
  assign in_data[1] = add_data;
  assign in_data[2] = mul_data;
  assign lw_ready   = in_ready[0];
  assign add_ready  = in_ready[1];
  assign mul_ready  = in_ready[2];

  // Per class: a completed handshake either enqueues (legal tag) or is dropped
  for (genvar gi = 0; gi < 3; gi++) begin : g_cls
    localparam cls_e CLS = cls_e'(gi);

    assign legal[gi]    = tag_in_range(CLS, in_tag[gi]);
    assign push[gi]     = in_valid[gi] && in_ready[gi] && legal[gi];
    assign bad[gi]      = in_valid[gi] && in_ready[gi] && !legal[gi];
    assign nonempty[gi] = (occ[gi] != '0);

    cdb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .din       ({in_tag[gi], in_data[gi]}),
      .pop       (pop[gi]),
      .head      (head[gi]),
      .occupancy (occ[gi]),
      .ready     (in_ready[gi])
    );
  end

  // Round-robin grant: first non-empty class starting at rr_ptr
  always_comb begin
    pop       = '0;
    found     = 1'b0;
    grant_cls = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found && nonempty[cand]) begin
        found     = 1'b1;
        grant_cls = cand;
        pop[cand] = 1'b1;
      end
      cand = next_cls(cand);
    end
  end

  // Next broadcast, pointer, error pulse and broadcast counter
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < 3; i++) begin
      if (pop[i]) begin
        sel_entry = head[i];
      end
    end
    cdb_d.valid   = found;
    cdb_d.tag     = sel_entry[ENTRY_W-1 -: UNIT_SIZE];
    cdb_d.data    = sel_entry[WORD_SIZE-1:0];
    rr_ptr_d      = found ? next_cls(grant_cls) : rr_ptr_q;
    tag_err_d     = |bad;
    bcast_count_d = bcast_count_q + {15'd0, cdb_q.valid};
  end

  // Registered CDB and arbiter state; reset drops any in-flight broadcast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_q         <= '0;
      rr_ptr_q      <= CLS_LW;
      tag_err_q     <= 1'b0;
      bcast_count_q <= '0;
    end else begin
      cdb_q         <= cdb_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_err_q     <= tag_err_d;
      bcast_count_q <= bcast_count_d;
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_tag     = cdb_q.tag;
  assign cdb_data    = cdb_q.data;
  assign tag_err     = tag_err_q;
  assign bcast_count = bcast_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based reference model,
// plus directed scenarios for reset, latency, fairness, full FIFO, bad tags
// and counter wrap.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_v [3];
  logic [7:0]  in_t [3];
  logic [31:0] in_d [3];

  logic        lw_ready, add_ready, mul_ready;
  logic        cdb_valid, tag_err;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [15:0] bcast_count;

  always #5 clk = ~clk;

  cdb_arbiter #(.WORD_SIZE(32), .UNIT_SIZE(8), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .lw_valid    (in_v[0]),
    .lw_tag      (in_t[0]),
    .lw_data     (in_d[0]),
    .lw_ready    (lw_ready),
    .add_valid   (in_v[1]),
    .add_tag     (in_t[1]),
    .add_data    (in_d[1]),
    .add_ready   (add_ready),
    .mul_valid   (in_v[2]),
    .mul_tag     (in_t[2]),
    .mul_data    (in_d[2]),
    .mul_ready   (mul_ready),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .tag_err     (tag_err),
    .bcast_count (bcast_count)
  );

  // Reference model state
  cdb_t        mq [3][$];
  int          rr;
  logic        exp_v, exp_err;
  logic [7:0]  exp_t;
  logic [31:0] exp_d;
  logic [15:0] exp_cnt;
  logic [7:0]  obs_log [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input int c, input logic [7:0] t);
    case (c)
      0:       return (t >= 8'h80) && (t <= 8'hDF);
      1:       return (t >= 8'h20) && (t <= 8'h3F);
      default: return (t >= 8'h40) && (t <= 8'h5F);
    endcase
  endfunction

  function automatic logic dut_ready(input int c);
    case (c)
      0:       return lw_ready;
      1:       return add_ready;
      default: return mul_ready;
    endcase
  endfunction

  function automatic logic [7:0] rand_tag(input int c);
    case (c)
      0:       return 8'(8'h80 + $urandom_range(0, 8'h5F));
      1:       return 8'(8'h20 + $urandom_range(0, 8'h1F));
      default: return 8'(8'h40 + $urandom_range(0, 8'h1F));
    endcase
  endfunction

  task automatic clear_inputs();
    for (int c = 0; c < 3; c++) begin
      in_v[c] = 1'b0;
      in_t[c] = 8'h00;
      in_d[c] = 32'h0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(0));
    chk({tag, "_tag"}, 64'(cdb_tag), 64'(0));
    chk({tag, "_data"}, 64'(cdb_data), 64'(0));
    chk({tag, "_err"}, 64'(tag_err), 64'(0));
    chk({tag, "_cnt"}, 64'(bcast_count), 64'(0));
    chk({tag, "_lw_rdy"}, 64'(lw_ready), 64'(1));
    chk({tag, "_add_rdy"}, 64'(add_ready), 64'(1));
    chk({tag, "_mul_rdy"}, 64'(mul_ready), 64'(1));
  endtask

  // Assert reset at a falling edge, hold two cycles, release at a falling edge
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    for (int c = 0; c < 3; c++) mq[c].delete();
    rr      = 0;
    exp_v   = 1'b0;
    exp_err = 1'b0;
    exp_t   = 8'h00;
    exp_d   = 32'h0;
    exp_cnt = 16'h0;
    repeat (2) @(negedge clk);
    check_idle("rst");
    rst = 1'b0;
  endtask

  // One clock: model the edge from the rules, then compare every output
  task automatic step();
    logic acc [3];
    logic g;
    cdb_t e;
    for (int c = 0; c < 3; c++) begin
      acc[c] = in_v[c] && (mq[c].size() < DEPTH);
      chk($sformatf("ready%0d", c), 64'(dut_ready(c)), 64'(mq[c].size() < DEPTH));
    end
    exp_cnt = exp_cnt + {15'd0, exp_v};
    g     = 1'b0;
    exp_v = 1'b0;
    exp_t = 8'h00;
    exp_d = 32'h0;
    for (int i = 0; i < 3; i++) begin
      int c;
      c = (rr + i) % 3;
      if (!g && mq[c].size() > 0) begin
        g     = 1'b1;
        e     = mq[c].pop_front();
        exp_v = 1'b1;
        exp_t = e.tag;
        exp_d = e.data;
        rr    = (c + 1) % 3;
      end
    end
    exp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (acc[c]) begin
        if (legal(c, in_t[c])) mq[c].push_back('{valid: 1'b1, tag: in_t[c], data: in_d[c]});
        else exp_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(exp_v));
    chk("cdb_tag", 64'(cdb_tag), 64'(exp_t));
    chk("cdb_data", 64'(cdb_data), 64'(exp_d));
    chk("tag_err", 64'(tag_err), 64'(exp_err));
    chk("bcast_count", 64'(bcast_count), 64'(exp_cnt));
    if (cdb_valid) obs_log.push_back(cdb_tag);
    @(negedge clk);
  endtask

  // Random offers; an offer that was not accepted is held unchanged
  task automatic rand_inputs();
    for (int c = 0; c < 3; c++) begin
      if (!(in_v[c] && mq[c].size() >= DEPTH)) begin
        in_v[c] = ($urandom_range(0, 3) != 0);
        in_t[c] = ($urandom_range(0, 15) == 0) ? 8'($urandom) : rand_tag(c);
        in_d[c] = $urandom;
      end
    end
  endtask

  initial begin
    logic [7:0] rr_exp [3];
    logic [7:0] nt;
    logic       seen_low, wrapped;
    int         k, nsteps;

    clear_inputs();
    rr_exp[0] = 8'h90;
    rr_exp[1] = 8'h30;
    rr_exp[2] = 8'h50;

    @(negedge clk);
    do_reset();

    // Single add result: accepted at edge 1, on the CDB after edge 2
    in_v[1] = 1'b1; in_t[1] = 8'h21; in_d[1] = 32'h5;
    step();
    in_v[1] = 1'b0;
    step();
    chk("add_valid", 64'(cdb_valid), 64'(1));
    chk("add_tag", 64'(cdb_tag), 64'(8'h21));
    chk("add_data", 64'(cdb_data), 64'(5));
    step();
    chk("add_gap", 64'(cdb_valid), 64'(0));
    chk("add_cnt", 64'(bcast_count), 64'(1));

    // All three classes every cycle: grant order lw, add, mul, ...
    do_reset();
    obs_log.delete();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 3; c++) begin
        in_v[c] = 1'b1; in_t[c] = rr_exp[c]; in_d[c] = 32'(i * 3 + c);
      end
      step();
    end
    clear_inputs();
    repeat (20) step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_order%0d", i), 64'((i < obs_log.size()) ? obs_log[i] : 8'h00), 64'(rr_exp[i % 3]));
    end

    // Fill lw FIFO while add/mul stay busy; held offers keep their tag
    do_reset();
    obs_log.delete();
    nt       = 8'h80;
    seen_low = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_v[0] = (nt <= 8'h87); in_t[0] = nt; in_d[0] = {24'h0, nt};
      in_v[1] = 1'b1; in_t[1] = 8'h30; in_d[1] = 32'h1;
      in_v[2] = 1'b1; in_t[2] = 8'h50; in_d[2] = 32'h2;
      if (!lw_ready) seen_low = 1'b1;
      if (in_v[0] && mq[0].size() < DEPTH) begin
        step();
        nt = nt + 8'h1;
      end else begin
        step();
      end
    end
    clear_inputs();
    repeat (30) step();
    chk("lw_full_seen", 64'(seen_low), 64'(1));
    k = 0;
    foreach (obs_log[i]) begin
      if (obs_log[i] >= 8'h80) begin
        chk($sformatf("lw_order%0d", k), 64'(obs_log[i]), 64'(8'h80 + k));
        k++;
      end
    end
    chk("lw_count", 64'(k), 64'(8));

    // Wrong class on the mul port: dropped, one-cycle tag_err
    do_reset();
    obs_log.delete();
    in_v[2] = 1'b1; in_t[2] = 8'h22; in_d[2] = 32'hDEAD;
    step();
    in_v[2] = 1'b0;
    chk("bad_err", 64'(tag_err), 64'(1));
    step();
    chk("bad_err_clr", 64'(tag_err), 64'(0));
    repeat (3) step();
    chk("bad_no_bcast", 64'(obs_log.size()), 64'(0));

    // Randomized traffic, including FIFO pointer wrap and illegal tags
    do_reset();
    repeat (3000) begin
      rand_inputs();
      step();
    end

    // Reset with three results queued: outputs clear immediately
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_v[c] = 1'b1; in_t[c] = rr_exp[c]; in_d[c] = 32'h77;
    end
    step();
    step();
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    do_reset();
    step();
    chk("midrst_empty", 64'(cdb_valid), 64'(0));

    // Counter wrap after 65536 broadcasts
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_v[c] = 1'b1; in_t[c] = rr_exp[c]; in_d[c] = 32'h1234;
    end
    wrapped = 1'b0;
    nsteps  = 0;
    while (!wrapped && nsteps < 70000) begin
      step();
      nsteps++;
      if (nsteps > 10 && exp_cnt == 16'h0) wrapped = 1'b1;
    end
    chk("wrap_reached", 64'(wrapped), 64'(1));
    chk("wrap_cnt", 64'(bcast_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
